// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Optional ALU_ARB_ILLEGAL_OP_EN: adds per-requester err outputs and forces illegal codes to AND.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [WIDTH-1:0]  i_req0_op1,
  input  logic [WIDTH-1:0]  i_req0_op2,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [WIDTH-1:0]  o_rsp0_result,
  output logic              o_rsp0_zf,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [WIDTH-1:0]  i_req1_op1,
  input  logic [WIDTH-1:0]  i_req1_op2,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [WIDTH-1:0]  o_rsp1_result,
  output logic              o_rsp1_zf,

`ifdef ALU_ARB_ILLEGAL_OP_EN
  output logic              o_rsp0_err,
  output logic              o_rsp1_err,
`endif

  output logic [WIDTH-1:0]  o_alu_op1,
  output logic [WIDTH-1:0]  o_alu_op2,
  output logic [CTRL_W-1:0] o_alu_control,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_zf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ptr;
  logic               owner;
  logic               grant0;
  logic               grant1;
  logic               grant;
  logic               rsp_hs;
  logic [WIDTH-1:0]   sel_op1;
  logic [WIDTH-1:0]   sel_op2;
  logic [CTRL_W-1:0]  sel_ctrl;
  logic [CTRL_W-1:0]  drive_ctrl;
  logic [WIDTH-1:0]   cap_result;
  logic               cap_zf;

  // A lone requester wins regardless of ptr; with both valid, ptr decides.
  always_comb begin
    grant0 = (state == IDLE) && i_req0_valid && (!ptr || !i_req1_valid);
    grant1 = (state == IDLE) && i_req1_valid && ( ptr || !i_req0_valid);
    grant  = grant0 || grant1;
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    sel_op1  = grant1 ? i_req1_op1  : i_req0_op1;
    sel_op2  = grant1 ? i_req1_op2  : i_req0_op2;
    sel_ctrl = grant1 ? i_req1_ctrl : i_req0_ctrl;
  end

  assign rsp_hs = owner ? i_rsp1_ready : i_rsp0_ready;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic illegal_sel;
  logic illegal_q;
  logic err0_q;
  logic err1_q;

  assign illegal_sel = !(sel_ctrl inside {CTRL_W'(0), CTRL_W'(1), CTRL_W'(2),
                                          CTRL_W'(6), CTRL_W'(7), CTRL_W'(12)});
  assign drive_ctrl  = illegal_sel ? '0 : sel_ctrl;
  // An illegal operation still runs through the ALU as AND, but its outcome is discarded.
  assign cap_result  = illegal_q ? '0 : i_alu_result;
  assign cap_zf      = illegal_q | i_alu_zf;
  assign o_rsp0_err  = err0_q;
  assign o_rsp1_err  = err1_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      illegal_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      if (grant) illegal_q <= illegal_sel;
      if (state == EXEC) begin
        if (owner) err1_q <= illegal_q;
        else       err0_q <= illegal_q;
      end
    end
  end
`else
  assign drive_ctrl = sel_ctrl;
  assign cap_result = i_alu_result;
  assign cap_zf     = i_alu_zf;
`endif

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= grant1;
        ptr   <= grant0;
      end
    end
  end

  // Operands are loaded only on a grant and otherwise hold their last value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_alu_op1     <= '0;
      o_alu_op2     <= '0;
      o_alu_control <= '0;
    end else if (grant) begin
      o_alu_op1     <= sel_op1;
      o_alu_op2     <= sel_op2;
      o_alu_control <= drive_ctrl;
    end
  end

  // Result and zf registers keep their value after valid drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp0_valid  <= 1'b0;
      o_rsp0_result <= '0;
      o_rsp0_zf     <= 1'b0;
      o_rsp1_valid  <= 1'b0;
      o_rsp1_result <= '0;
      o_rsp1_zf     <= 1'b0;
    end else if (state == EXEC) begin
      if (owner) begin
        o_rsp1_valid  <= 1'b1;
        o_rsp1_result <= cap_result;
        o_rsp1_zf     <= cap_zf;
      end else begin
        o_rsp0_valid  <= 1'b1;
        o_rsp0_result <= cap_result;
        o_rsp0_zf     <= cap_zf;
      end
    end else if (state == RESP && rsp_hs) begin
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
    end
  end

endmodule
